// File: rtl/irq_ctrl.sv
// irq_ctrl: bus-mapped interrupt controller with edge/level pending latches, masking and nested req/ack/eoi handshake.
// Define IRQ_PRIO_EN for per-source programmable priority registers (offsets 5/6); otherwise lower index wins.
module irq_ctrl #(
  parameter int                   CPU_WIDTH = 16,
  parameter int                   IRQ_NUM   = 8,
  parameter logic [CPU_WIDTH-1:0] BASE_ADDR = 16'hFF40,
  parameter int                   PRIO_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CPU_WIDTH-1:0] bus_addr,
  input  logic                 bus_we,
  input  logic [CPU_WIDTH-1:0] bus_wd,
  output logic [CPU_WIDTH-1:0] bus_rd,
  input  logic [IRQ_NUM-1:0]   irq_src,
  output logic                 irq_req,
  output logic [3:0]           irq_id,
  input  logic                 irq_ack,
  input  logic                 irq_eoi
);
`ifdef IRQ_PRIO_EN
  localparam int RW = PRIO_W + 4;
`else
  localparam int RW = 4;
`endif
  typedef enum logic {IDLE, REQ} state_t;
  state_t state_q, state_d;
  logic [IRQ_NUM-1:0] pend_q, pend_d, mask_q, mask_d, trig_q, trig_d, act_q, act_d, src_q;
  logic [IRQ_NUM-1:0] wd, w1c, sel_oh, ack_oh, eoi_oh, elig, elig_d;
  logic req_q, req_d, ack, wen, in_range, cand_v, top_v, unused;
  logic [3:0] id_q, id_d, cand, top;
  logic [RW-1:0] cand_r, top_r;
  logic [RW-1:0] rank [IRQ_NUM];
  logic [2*CPU_WIDTH-1:0] prio_ext;
  logic [CPU_WIDTH-1:0] off;
  assign off = bus_addr - BASE_ADDR;
  assign in_range = off < CPU_WIDTH'(8);
  assign wen = bus_we && in_range;
  assign wd = bus_wd[IRQ_NUM-1:0];
  // Rank = {priority field, inverted index}: unique per source, so ties always resolve to the lower index
`ifdef IRQ_PRIO_EN
  localparam int PW = IRQ_NUM * PRIO_W;
  logic [PW-1:0] prio_q, prio_d;
  logic [2*CPU_WIDTH-1:0] prio_wr;
  assign prio_ext = (2*CPU_WIDTH)'(prio_q);
  assign prio_wr = wen && off[2:0] == 3'd5 ? {prio_ext[2*CPU_WIDTH-1:CPU_WIDTH], bus_wd} :
                   wen && off[2:0] == 3'd6 ? {bus_wd, prio_ext[CPU_WIDTH-1:0]} : prio_ext;
  assign prio_d = prio_wr[PW-1:0];
  assign unused = ^prio_wr;
  always_ff @(posedge clk) prio_q <= !rst_n ? '0 : prio_d;
  always_comb for (int i = 0; i < IRQ_NUM; i++) rank[i] = {prio_q[i*PRIO_W +: PRIO_W], 4'(15 - i)};
`else
  assign prio_ext = '0;
  assign unused = ^bus_wd;
  always_comb for (int i = 0; i < IRQ_NUM; i++) rank[i] = 4'(15 - i);
`endif
  assign elig = pend_q & mask_q & ~act_q;
  always_comb begin
    cand_v = 1'b0;
    cand = '0;
    cand_r = '0;
    top_v = 1'b0;
    top = '0;
    top_r = '0;
    for (int i = 0; i < IRQ_NUM; i++) begin
      if (elig[i] && (!cand_v || rank[i] > cand_r)) begin
        cand_v = 1'b1;
        cand = 4'(i);
        cand_r = rank[i];
      end
      if (act_q[i] && (!top_v || rank[i] > top_r)) begin
        top_v = 1'b1;
        top = 4'(i);
        top_r = rank[i];
      end
    end
  end
  assign ack = state_q == REQ && irq_ack;
  assign sel_oh = IRQ_NUM'(1) << id_q;
  assign ack_oh = ack ? sel_oh : '0;
  assign eoi_oh = irq_eoi && top_v ? IRQ_NUM'(1) << top : '0;
  assign w1c = wen && off[2:0] == 3'd0 ? wd : '0;
  assign pend_d = (trig_q & ((pend_q & ~w1c & ~ack_oh) | (irq_src & ~src_q))) | (~trig_q & irq_src);
  assign mask_d = wen && off[2:0] == 3'd1 ? wd : mask_q;
  assign trig_d = wen && off[2:0] == 3'd2 ? wd : trig_q;
  assign act_d = (act_q | ack_oh) & ~eoi_oh;
  // Cancel looks at next-cycle eligibility so a W1C/mask/level drop removes the request on the same edge
  assign elig_d = pend_d & mask_d;
  always_comb begin
    state_d = state_q;
    req_d = req_q;
    id_d = id_q;
    if (state_q == IDLE && cand_v && (!top_v || cand_r > top_r)) begin
      state_d = REQ;
      req_d = 1'b1;
      id_d = cand;
    end else if (state_q == REQ && (ack || !(|(elig_d & sel_oh)))) begin
      state_d = IDLE;
      req_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q <= 1'b0;
      id_q <= '0;
      pend_q <= '0;
      mask_q <= '0;
      trig_q <= '0;
      act_q <= '0;
      src_q <= '0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      id_q <= id_d;
      pend_q <= pend_d;
      mask_q <= mask_d;
      trig_q <= trig_d;
      act_q <= act_d;
      src_q <= irq_src;
    end
  end
  assign irq_req = req_q;
  assign irq_id = id_q;
  assign bus_rd = !in_range ? '0 :
                  off[2:0] == 3'd0 ? CPU_WIDTH'(pend_q) :
                  off[2:0] == 3'd1 ? CPU_WIDTH'(mask_q) :
                  off[2:0] == 3'd2 ? CPU_WIDTH'(trig_q) :
                  off[2:0] == 3'd3 ? CPU_WIDTH'(act_q) :
                  off[2:0] == 3'd4 ? {req_q, (CPU_WIDTH-5)'(0), id_q} :
                  off[2:0] == 3'd5 ? prio_ext[CPU_WIDTH-1:0] :
                  off[2:0] == 3'd6 ? prio_ext[2*CPU_WIDTH-1:CPU_WIDTH] : '0;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios for irq_ctrl, checked every cycle against a behavioural model plus literal expectations.
module tb_irq_ctrl;
  localparam logic [15:0] BASE = 16'hFF40;
  logic clk = 0, rst_n = 0, bus_we = 0, irq_ack = 0, irq_eoi = 0;
  logic [15:0] bus_addr = 0, bus_wd = 0, bus_rd;
  logic [7:0] irq_src = 0;
  logic irq_req;
  logic [3:0] irq_id;
  int n_tests = 0, n_fail = 0;
  bit chk_en = 0;

  irq_ctrl dut (.clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_we(bus_we), .bus_wd(bus_wd),
                .bus_rd(bus_rd), .irq_src(irq_src), .irq_req(irq_req), .irq_id(irq_id),
                .irq_ack(irq_ack), .irq_eoi(irq_eoi));

  always #5 clk = ~clk;

  bit [7:0] m_pend, m_mask, m_trig, m_act, m_src;
  bit m_req;
  int m_id;
`ifdef IRQ_PRIO_EN
  int m_prio [8];
`endif

  function automatic bit beats(int a, int b);
`ifdef IRQ_PRIO_EN
    return m_prio[a] > m_prio[b] || (m_prio[a] == m_prio[b] && a < b);
`else
    return a < b;
`endif
  endfunction

  function automatic logic [15:0] m_rd(logic [15:0] a);
    logic [15:0] o, r;
    o = a - BASE;
    r = 0;
    if (o == 0) r = 16'(m_pend);
    if (o == 1) r = 16'(m_mask);
    if (o == 2) r = 16'(m_trig);
    if (o == 3) r = 16'(m_act);
    if (o == 4) r = {m_req, 11'b0, 4'(m_id)};
`ifdef IRQ_PRIO_EN
    if (o == 5) for (int i = 0; i < 8; i++) r[2*i +: 2] = 2'(m_prio[i]);
`endif
    return r;
  endfunction

  always @(posedge clk) begin
    int cand, top;
    bit ack, wen;
    bit [7:0] np, nm, nt, na;
    logic [15:0] o;
    if (!rst_n) begin
      m_pend = 0; m_mask = 0; m_trig = 0; m_act = 0; m_src = 0; m_req = 0; m_id = 0;
`ifdef IRQ_PRIO_EN
      for (int i = 0; i < 8; i++) m_prio[i] = 0;
`endif
    end else begin
      cand = -1;
      top = -1;
      for (int i = 0; i < 8; i++) begin
        if (m_pend[i] && m_mask[i] && !m_act[i] && (cand < 0 || beats(i, cand))) cand = i;
        if (m_act[i] && (top < 0 || beats(i, top))) top = i;
      end
      ack = m_req && irq_ack;
      o = bus_addr - BASE;
      wen = bus_we && o < 8;
      nm = wen && o == 1 ? bus_wd[7:0] : m_mask;
      nt = wen && o == 2 ? bus_wd[7:0] : m_trig;
      for (int i = 0; i < 8; i++)
        np[i] = m_trig[i] ? (irq_src[i] && !m_src[i]) ||
                            (m_pend[i] && !(wen && o == 0 && bus_wd[i]) && !(ack && m_id == i))
                          : irq_src[i];
      na = m_act;
      if (ack) na[m_id] = 1;
      if (irq_eoi && top >= 0) na[top] = 0;
      if (m_req) begin
        if (ack || !(np[m_id] && nm[m_id])) m_req = 0;
      end else if (cand >= 0 && (top < 0 || beats(cand, top))) begin
        m_req = 1;
        m_id = cand;
      end
`ifdef IRQ_PRIO_EN
      if (wen && o == 5) for (int i = 0; i < 8; i++) m_prio[i] = int'(bus_wd[2*i +: 2]);
`endif
      m_pend = np; m_mask = nm; m_trig = nt; m_act = na; m_src = irq_src;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    check("cyc_req", 32'(irq_req), 32'(m_req));
    check("cyc_id", 32'(irq_id), 32'(m_id));
    check("cyc_rd", 32'(bus_rd), 32'(m_rd(bus_addr)));
  end

  task automatic tick();
    @(posedge clk);
    #2;
    bus_we = 0; irq_ack = 0; irq_eoi = 0;
  endtask

  task automatic wr(input int off, input logic [15:0] d);
    bus_addr = BASE + 16'(off); bus_wd = d; bus_we = 1;
    tick();
  endtask

  task automatic rd(input string name, input int off, input logic [15:0] exp);
    bus_addr = BASE + 16'(off);
    #1;
    check(name, 32'(bus_rd), 32'(exp));
  endtask

  task automatic lit(input string name, input logic req, input int id);
    check({name, "_req"}, 32'(irq_req), 32'(req));
    if (req) check({name, "_id"}, 32'(irq_id), 32'(id));
  endtask

  task automatic reset();
    rst_n = 0; irq_src = 0;
    tick(); tick();
    rst_n = 1;
  endtask

  initial begin
    reset();
    chk_en = 1;
    lit("rst", 0, 0); check("rst_id", 32'(irq_id), 0);
    rd("rst_status", 4, 0); rd("rst_pend", 0, 0); rd("rst_mask", 1, 0); rd("rst_act", 3, 0);
    // edge source 3: pending after one edge, request after two, ack moves it to in-service
    wr(1, 16'h0008); wr(2, 16'h0008);
    irq_src = 8'h08; tick(); irq_src = 0;
    rd("t1_pend", 0, 16'h0008); lit("t1_lat", 0, 0);
    tick(); lit("t1_req", 1, 3); rd("t1_status", 4, 16'h8003);
    irq_ack = 1; tick();
    rd("t1_pend_ack", 0, 0); rd("t1_act", 3, 16'h0008); lit("t1_drop", 0, 0);
    irq_eoi = 1; tick(); rd("t1_eoi", 3, 0);
    // level source 1 held high re-requests after eoi, then cancels when it drops
    reset();
    wr(1, 16'h0002); irq_src = 8'h02; tick();
    rd("t2_pend", 0, 16'h0002); lit("t2_lat", 0, 0);
    tick(); lit("t2_req", 1, 1);
    irq_ack = 1; tick(); lit("t2_ack", 0, 0); rd("t2_pend_lvl", 0, 16'h0002); rd("t2_act", 3, 16'h0002);
    irq_eoi = 1; tick(); lit("t2_eoi", 0, 0); rd("t2_act0", 3, 0);
    tick(); lit("t2_rereq", 1, 1);
    irq_src = 0; tick(); lit("t2_cancel", 0, 0); rd("t2_pend0", 0, 0);
    // nesting: id2 in service; id5 blocked, id0 nests; id5 only after both eoi
    reset();
    wr(1, 16'h0025); wr(2, 16'h0025);
    irq_src = 8'h04; tick(); irq_src = 0; tick(); lit("t3_req2", 1, 2);
    irq_ack = 1; tick(); rd("t3_act2", 3, 16'h0004);
    irq_src = 8'h20; tick(); irq_src = 0; tick(); tick();
    lit("t3_block5", 0, 0); rd("t3_pend5", 0, 16'h0020);
    irq_src = 8'h01; tick(); irq_src = 0; tick(); lit("t3_req0", 1, 0);
    irq_ack = 1; tick(); rd("t3_act05", 3, 16'h0005);
    irq_eoi = 1; tick(); rd("t3_eoi0", 3, 16'h0004);
    tick(); lit("t3_still", 0, 0);
    irq_eoi = 1; tick(); rd("t3_eoi2", 3, 0);
    tick(); lit("t3_req5", 1, 5);
    // cancel by W1C; a later ack in IDLE is ignored; ack in the cancel cycle wins
    reset();
    wr(1, 16'h0010); wr(2, 16'h0010);
    irq_src = 8'h10; tick(); irq_src = 0; tick(); lit("t4_req", 1, 4);
    wr(0, 16'h0010); lit("t4_cancel", 0, 0); rd("t4_pend", 0, 0);
    irq_ack = 1; tick(); rd("t4_act", 3, 0); lit("t4_ign", 0, 0);
    irq_src = 8'h10; tick(); irq_src = 0; tick(); lit("t4_req2", 1, 4);
    irq_ack = 1; wr(0, 16'h0010); rd("t4_ackwin", 3, 16'h0010); rd("t4_pend2", 0, 0);
    // collisions and address decode boundaries
    reset();
    wr(1, 16'hFFFF); rd("t5_mask_w", 1, 16'h00FF);
    wr(1, 16'h0008); wr(2, 16'h0008);
    irq_src = 8'h08; tick(); irq_src = 0; tick(); lit("t5_req", 1, 3);
    irq_src = 8'h08; wr(0, 16'h0008); irq_src = 0;
    rd("t5_set_w1c", 0, 16'h0008); lit("t5_keep", 1, 3);
    tick();
    irq_src = 8'h08; irq_ack = 1; tick(); irq_src = 0;
    rd("t5_set_ack", 0, 16'h0008); rd("t5_act", 3, 16'h0008);
    rd("t5_oor_hi", 8, 0); rd("t5_oor_lo", -1, 0); rd("t5_res", 7, 0);
`ifndef IRQ_PRIO_EN
    wr(5, 16'hFFFF); rd("t5_prio_off", 5, 0);
`endif
    // two simultaneous sources: order depends on priority configuration
    reset();
    wr(1, 16'h0003); wr(2, 16'h0003);
`ifdef IRQ_PRIO_EN
    wr(5, 16'h000D); rd("t6_prio", 5, 16'h000D);
`endif
    irq_src = 8'h03; tick(); irq_src = 0; tick();
`ifdef IRQ_PRIO_EN
    lit("t6_first", 1, 1);
`else
    lit("t6_first", 1, 0);
`endif
    irq_ack = 1; tick(); tick(); lit("t6_blocked", 0, 0);
    irq_eoi = 1; tick(); tick();
`ifdef IRQ_PRIO_EN
    lit("t6_second", 1, 0);
`else
    lit("t6_second", 1, 1);
`endif
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
